// File: rtl/alu_op_sequencer.sv
// Drives one decoded LEGv8 request into an external combinational ALU, waits SETTLE cycles, returns BusW/Zero.
// Latency: response valid 2+SETTLE cycles after accept (1 cycle for an undecodable opcode); one request in flight.
// Backpressure: req_ready only in IDLE; response held in RESP until rsp_ready. Optional branch resolution: ALU_SEQ_CBZ_EN.
module alu_op_sequencer #(
    parameter int N      = 64,
    parameter int TAG_W  = 4,
    parameter int SETTLE = 2
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [10:0]      req_opcode,
    input  logic [N-1:0]     req_a,
    input  logic [N-1:0]     req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [N-1:0]     alu_busa,
    output logic [N-1:0]     alu_busb,
    output logic [3:0]       alu_ctrl,
    input  logic [N-1:0]     alu_busw,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [N-1:0]     rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_taken
);

    typedef enum logic [1:0] {IDLE, DRIVE, WAIT, RESP} state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               ready_q;
    logic [N-1:0]       busa_q, busa_d, busb_q, busb_d;
    logic [3:0]         ctrl_q, ctrl_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [N-1:0]       rsp_result_q, rsp_result_d;
    logic               rsp_zero_q, rsp_zero_d;
    logic               rsp_err_q, rsp_err_d;
    logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
    logic               dec_err;
    logic [3:0]         dec_ctrl;
`ifdef ALU_SEQ_CBZ_EN
    logic               cbz_q, cbz_d, cbnz_q, cbnz_d, taken_q, taken_d;
`endif

    always_comb begin
        dec_err  = 1'b0;
        dec_ctrl = 4'b0000;
        casez (req_opcode)
            11'b10001011000: dec_ctrl = 4'b0010;
            11'b11001011000: dec_ctrl = 4'b0110;
            11'b10001010000: dec_ctrl = 4'b0000;
            11'b10101010000: dec_ctrl = 4'b0001;
            11'b11111000010,
            11'b11111000000: dec_ctrl = 4'b0010;
            11'b110100101??: dec_ctrl = 4'b0111;
            11'b1011010????: dec_ctrl = 4'b0111;
            default:         dec_err  = 1'b1;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        busa_d       = busa_q;
        busb_d       = busb_q;
        ctrl_d       = ctrl_q;
        tag_d        = tag_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;
        rsp_tag_d    = rsp_tag_q;
`ifdef ALU_SEQ_CBZ_EN
        cbz_d        = cbz_q;
        cbnz_d       = cbnz_q;
        taken_d      = taken_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    tag_d = req_tag;
                    if (dec_err) begin
                        // Undecodable: answer straight away, leave the ALU buses untouched.
                        state_d      = RESP;
                        rsp_err_d    = 1'b1;
                        rsp_result_d = '0;
                        rsp_zero_d   = 1'b0;
                        rsp_tag_d    = req_tag;
`ifdef ALU_SEQ_CBZ_EN
                        taken_d      = 1'b0;
`endif
                    end else begin
                        state_d = DRIVE;
                        busa_d  = req_a;
                        busb_d  = req_b;
                        ctrl_d  = dec_ctrl;
`ifdef ALU_SEQ_CBZ_EN
                        cbz_d   = (req_opcode[10:3] == 8'b10110100);
                        cbnz_d  = (req_opcode[10:3] == 8'b10110101);
`endif
                    end
                end
            end
            DRIVE: begin
                cnt_d   = SETTLE_LD;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d      = RESP;
                    rsp_result_d = alu_busw;
                    rsp_zero_d   = alu_zero;
                    rsp_err_d    = 1'b0;
                    rsp_tag_d    = tag_q;
`ifdef ALU_SEQ_CBZ_EN
                    taken_d      = (cbz_q & alu_zero) | (cbnz_q & ~alu_zero);
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ready_q      <= 1'b0;
            busa_q       <= '0;
            busb_q       <= '0;
            ctrl_q       <= '0;
            tag_q        <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_tag_q    <= '0;
`ifdef ALU_SEQ_CBZ_EN
            cbz_q        <= 1'b0;
            cbnz_q       <= 1'b0;
            taken_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            // Registered so req_ready reads 0 in the cycle right after reset.
            ready_q      <= (state_d == IDLE);
            busa_q       <= busa_d;
            busb_q       <= busb_d;
            ctrl_q       <= ctrl_d;
            tag_q        <= tag_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
            rsp_tag_q    <= rsp_tag_d;
`ifdef ALU_SEQ_CBZ_EN
            cbz_q        <= cbz_d;
            cbnz_q       <= cbnz_d;
            taken_q      <= taken_d;
`endif
        end
    end

    assign req_ready  = ready_q;
    assign rsp_valid  = (state_q == RESP);
    assign alu_busa   = busa_q;
    assign alu_busb   = busb_q;
    assign alu_ctrl   = ctrl_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_tag    = rsp_tag_q;
`ifdef ALU_SEQ_CBZ_EN
    assign rsp_taken  = taken_q;
`else
    assign rsp_taken  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU on the bus side, opcode-level reference model, directed + random requests.
module tb_alu_op_sequencer;

    localparam int N = 64;
    localparam int TAG_W = 4;
    localparam int SETTLE = 2;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_MOVZ = 11'b11010010100;
    localparam logic [10:0] OP_CBZ  = 11'b10110100000;
    localparam logic [10:0] OP_CBNZ = 11'b10110101000;

    logic             CLK = 1'b0;
    logic             Reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [10:0]      req_opcode = '0;
    logic [N-1:0]     req_a = '0, req_b = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic [N-1:0]     alu_busa, alu_busb, alu_busw;
    logic [3:0]       alu_ctrl;
    logic             alu_zero;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [N-1:0]     rsp_result;
    logic             rsp_zero, rsp_err, rsp_taken;
    logic [TAG_W-1:0] rsp_tag;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    alu_op_sequencer #(.N(N), .TAG_W(TAG_W), .SETTLE(SETTLE)) dut (
        .CLK(CLK), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .alu_busa(alu_busa), .alu_busb(alu_busb), .alu_ctrl(alu_ctrl),
        .alu_busw(alu_busw), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_err(rsp_err), .rsp_tag(rsp_tag), .rsp_taken(rsp_taken)
    );

    // External ALU: purely combinational on the sequencer's registered buses.
    always_comb begin
        alu_busw = '0;
        case (alu_ctrl)
            4'b0000: alu_busw = alu_busa & alu_busb;
            4'b0001: alu_busw = alu_busa | alu_busb;
            4'b0010: alu_busw = alu_busa + alu_busb;
            4'b0110: alu_busw = alu_busa - alu_busb;
            4'b0111: alu_busw = alu_busb;
            default: alu_busw = '0;
        endcase
    end
    assign alu_zero = (alu_busw == '0);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Instruction-level meaning of each opcode, independent of the ALU control encoding.
    function automatic void ref_model(input logic [10:0] op, input logic [63:0] a, input logic [63:0] b,
                                      output logic err, output logic [63:0] res, output logic [3:0] ctrl,
                                      output logic taken);
        err = 1'b0; res = '0; ctrl = '0; taken = 1'b0;
        if (op == OP_ADD || op == OP_LDUR || op == OP_STUR) begin res = a + b; ctrl = 4'b0010; end
        else if (op == OP_SUB) begin res = a - b; ctrl = 4'b0110; end
        else if (op == OP_AND) begin res = a & b; ctrl = 4'b0000; end
        else if (op == OP_ORR) begin res = a | b; ctrl = 4'b0001; end
        else if (op[10:2] == 9'b110100101) begin res = b; ctrl = 4'b0111; end
        else if (op[10:3] == 8'b10110100 || op[10:3] == 8'b10110101) begin
            res = b; ctrl = 4'b0111;
`ifdef ALU_SEQ_CBZ_EN
            taken = op[3] ? (b != 0) : (b == 0);
`endif
        end
        else err = 1'b1;
    endfunction

    task automatic do_req(input logic [10:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [3:0] tag, input int hold);
        logic e, tk; logic [63:0] res; logic [3:0] ctrl; logic [3:0] prev_ctrl;
        int w, lat;
        ref_model(op, a, b, e, res, ctrl, tk);
        w = 0;
        while (!req_ready && w < 10) begin @(posedge CLK); #1; w++; end
        check("req_ready_idle", 64'(req_ready), 64'd1);
        prev_ctrl = alu_ctrl;
        req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b; req_tag = tag;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        if (hold == 0) rsp_ready = 1'b1;
        if (e) check("alu_ctrl_kept", 64'(alu_ctrl), 64'(prev_ctrl));
        else begin
            check("alu_ctrl", 64'(alu_ctrl), 64'(ctrl));
            check("alu_busa", alu_busa, a);
            check("alu_busb", alu_busb, b);
        end
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            check("req_ready_busy", 64'(req_ready), 64'd0);
            @(posedge CLK); #1; lat++;
        end
        check("latency", 64'(lat), e ? 64'd1 : 64'(2 + SETTLE));
        check("rsp_err", 64'(rsp_err), 64'(e));
        check("rsp_result", rsp_result, res);
        check("rsp_zero", 64'(rsp_zero), 64'(!e && res == 0));
        check("rsp_tag", 64'(rsp_tag), 64'(tag));
        check("rsp_taken", 64'(rsp_taken), 64'(tk));
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK); #1;
            check("bp_valid", 64'(rsp_valid), 64'd1);
            check("bp_ready", 64'(req_ready), 64'd0);
            check("bp_result", rsp_result, res);
            check("bp_tag", 64'(rsp_tag), 64'(tag));
        end
        rsp_ready = 1'b1;
        @(posedge CLK); #1;
        rsp_ready = 1'b0;
        check("rsp_done", 64'(rsp_valid), 64'd0);
        check("ready_after", 64'(req_ready), 64'd1);
    endtask

    initial begin
        logic [10:0] op;
        logic [63:0] a, b;
        int seen;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_alu_busa", alu_busa, 64'd0);
        check("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
        check("rst_rsp_result", rsp_result, 64'd0);
        check("rst_rsp_tag", 64'(rsp_tag), 64'd0);
        Reset = 1'b0;
        @(posedge CLK); #1;

        do_req(OP_ADD, 64'd5, 64'd7, 4'd3, 0);
        do_req(OP_SUB, 64'd9, 64'd9, 4'd5, 0);
        do_req(OP_ORR, 64'hF0, 64'h0F, 4'd6, 5);
        do_req(11'b00000000000, 64'd1, 64'd2, 4'd9, 0);
        do_req(OP_CBZ,  64'd0, 64'd0, 4'd1, 0);
        do_req(OP_CBNZ, 64'd0, 64'd0, 4'd2, 0);
        do_req(OP_CBNZ, 64'd0, 64'd4, 4'd4, 1);

        // Reset while the request sits in WAIT: it must vanish without a response.
        req_valid = 1'b1; req_opcode = OP_ADD; req_a = 64'd11; req_b = 64'd22; req_tag = 4'hA;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        @(posedge CLK); #1;
        Reset = 1'b1;
        @(posedge CLK); #1;
        Reset = 1'b0;
        check("abort_busa", alu_busa, 64'd0);
        check("abort_busb", alu_busb, 64'd0);
        check("abort_ctrl", 64'(alu_ctrl), 64'd0);
        check("abort_valid", 64'(rsp_valid), 64'd0);
        check("abort_ready", 64'(req_ready), 64'd0);
        check("abort_result", rsp_result, 64'd0);
        check("abort_tag", 64'(rsp_tag), 64'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid) seen++;
            @(posedge CLK); #1;
        end
        check("abort_no_rsp", 64'(seen), 64'd0);
        do_req(OP_ADD, 64'd100, 64'd23, 4'd7, 0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0: op = OP_ADD;
                1: op = OP_SUB;
                2: op = OP_AND;
                3: op = OP_ORR;
                4: op = OP_LDUR;
                5: op = OP_STUR;
                6: op = OP_MOVZ | 11'($urandom_range(0, 3));
                7: op = OP_CBZ | 11'($urandom_range(0, 7));
                8: op = OP_CBNZ | 11'($urandom_range(0, 7));
                default: op = 11'($urandom);
            endcase
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) b = '0;
            if ($urandom_range(0, 3) == 0) a = b;
            do_req(op, a, b, 4'($urandom), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
